// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-entry holding register.
// Flags framing errors and overruns as one-cycle pulses.
module uart_rx #(
  parameter int BIT_CYCLES = 5209,
  parameter int HALF_BIT   = BIT_CYCLES / 2
) (
  input  logic       sclk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  localparam logic [13:0] BIT_LD  = 14'(BIT_CYCLES - 1);
  localparam logic [13:0] HALF_LD = 14'(HALF_BIT - 1);

  state_t      state;
  state_t      state_nx;
  logic        s1;
  logic        rx_s;
  logic [13:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shift;
  logic        cnt_zero;
  logic        deliver;
  logic        ferr_hit;

  assign cnt_zero = (cnt == 14'd0);

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge sclk) begin
    if (reset) begin
      s1   <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      s1   <= rxd;
      rx_s <= s1;
    end
  end

  // State register.
  always_ff @(posedge sclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (!rx_s) state_nx = START;
      START: if (cnt_zero) state_nx = rx_s ? IDLE : DATA;
      DATA:  if (cnt_zero && idx == 3'd7) state_nx = STOP;
      STOP:  if (cnt_zero) state_nx = rx_s ? IDLE : BRK;
      BRK:   if (rx_s) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Decoded FSM outputs.
  always_comb begin
    busy     = (state != IDLE);
    deliver  = (state == STOP) && cnt_zero && rx_s;
    ferr_hit = (state == STOP) && cnt_zero && !rx_s;
  end

  // Bit timer, bit index and shift register.
  always_ff @(posedge sclk) begin
    if (reset) begin
      cnt   <= 14'd0;
      idx   <= 3'd0;
      shift <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!rx_s) cnt <= HALF_LD;
        end
        START: begin
          if (!cnt_zero) begin
            cnt <= cnt - 14'd1;
          end else if (!rx_s) begin
            cnt <= BIT_LD;
            idx <= 3'd0;
          end
        end
        DATA: begin
          if (!cnt_zero) begin
            cnt <= cnt - 14'd1;
          end else begin
            shift[idx] <= rx_s;
            cnt        <= BIT_LD;
            if (idx != 3'd7) idx <= idx + 3'd1;
          end
        end
        STOP: begin
          if (!cnt_zero) cnt <= cnt - 14'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Holding register with ack handshake and status pulses.
  always_ff @(posedge sclk) begin
    if (reset) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_hit;
      overrun   <= deliver && rx_valid && !rx_ack;
      if (deliver) begin
        if (!rx_valid || rx_ack) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 16 cycles per bit.
// Frames are driven bit-synchronously; outputs checked 1 time unit after edges.
module tb_uart_rx;

  logic       sclk = 1'b0;
  logic       reset;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_ferr = 0;
  int n_ovr  = 0;
  int rise_cyc = -1;
  int t_start = 0;
  logic prev_valid = 1'b0;
  logic [7:0] log_q[$];
  int f0;
  int o0;

  uart_rx #(.BIT_CYCLES(16)) dut (
    .sclk(sclk),
    .reset(reset),
    .rxd(rxd),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ack(rx_ack),
    .frame_err(frame_err),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 sclk = ~sclk;

  always @(posedge sclk) cyc <= cyc + 1;

  // Pulse counters and rx_valid rise time, sampled mid-cycle.
  always @(negedge sclk) begin
    if (frame_err) n_ferr <= n_ferr + 1;
    if (overrun)   n_ovr  <= n_ovr + 1;
    if (rx_valid && !prev_valid) rise_cyc <= cyc;
    prev_valid <= rx_valid;
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
  endtask

  // mode 0: no ack; 1: ack one cycle after rx_valid and log the byte;
  // 2: ack exactly on the stop-sample edge.
  task automatic send_frame(input logic [7:0] d, input logic sb,
                            input int nbits, input int mode);
    logic b;
    t_start = cyc + 1;
    for (int k = 0; k < nbits; k++) begin
      if (k == 0)      b = 1'b0;
      else if (k == 9) b = sb;
      else             b = d[k-1];
      rxd = b;
      for (int j = 0; j < 16; j++) begin
        if (k == 9 && mode == 2) rx_ack = (j == 10);
        if (k == 9 && mode == 1) begin
          if (rx_ack) rx_ack = 1'b0;
          else if (rx_valid) begin
            log_q.push_back(rx_data);
            rx_ack = 1'b1;
          end
        end
        tick();
      end
    end
    rx_ack = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    rxd    = 1'b1;
    rx_ack = 1'b0;
    #1;
    repeat (3) tick();
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    reset = 1'b0;
    repeat (5) tick();

    // single frame, latency check
    f0 = n_ferr; o0 = n_ovr;
    send_frame(8'hA5, 1'b1, 10, 0);
    chk("a5_latency", rise_cyc - t_start, 154);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_valid", rx_valid, 1);
    chk("a5_ferr", n_ferr - f0, 0);
    chk("a5_ovr", n_ovr - o0, 0);
    ack();
    chk("ack_clr", rx_valid, 0);
    chk("ack_keep", rx_data, 8'hA5);
    repeat (4) tick();

    // glitch
    rxd = 1'b0;
    repeat (3) tick();
    chk("gl_busy", busy, 1);
    rxd = 1'b1;
    repeat (20) tick();
    chk("gl_idle", busy, 0);
    chk("gl_valid", rx_valid, 0);
    chk("gl_ferr", n_ferr - f0, 0);
    chk("gl_ovr", n_ovr - o0, 0);

    // framing error, held-low line
    send_frame(8'h3C, 1'b0, 10, 0);
    repeat (40) tick();
    chk("fe_pulse", n_ferr - f0, 1);
    chk("fe_valid", rx_valid, 0);
    chk("fe_busy", busy, 1);
    rxd = 1'b1;
    repeat (2) tick();
    chk("fe_busy2", busy, 1);
    tick();
    chk("fe_idle", busy, 0);
    repeat (5) tick();
    send_frame(8'h11, 1'b1, 10, 0);
    chk("fe_next", rx_data, 8'h11);
    chk("fe_nvalid", rx_valid, 1);
    chk("fe_once", n_ferr - f0, 1);

    // reset during data bit 4 of 0xFF, holding register still full
    send_frame(8'hFF, 1'b1, 5, 0);
    rxd = 1'b1;
    repeat (8) tick();
    reset = 1'b1;
    tick();
    chk("mr_data", rx_data, 8'h00);
    chk("mr_valid", rx_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_ferr", frame_err, 0);
    chk("mr_ovr", overrun, 0);
    reset = 1'b0;
    repeat (20) tick();
    send_frame(8'h5A, 1'b1, 10, 0);
    chk("mr_5a", rx_data, 8'h5A);
    chk("mr_5avalid", rx_valid, 1);
    ack();
    repeat (3) tick();

    // overrun without ack
    f0 = n_ferr; o0 = n_ovr;
    send_frame(8'h01, 1'b1, 10, 0);
    send_frame(8'h02, 1'b1, 10, 0);
    chk("ov_data", rx_data, 8'h01);
    chk("ov_valid", rx_valid, 1);
    chk("ov_pulse", n_ovr - o0, 1);
    ack();
    repeat (3) tick();

    // ack on the delivery edge
    o0 = n_ovr;
    send_frame(8'h01, 1'b1, 10, 0);
    send_frame(8'h02, 1'b1, 10, 2);
    chk("oa_data", rx_data, 8'h02);
    chk("oa_valid", rx_valid, 1);
    chk("oa_novr", n_ovr - o0, 0);
    ack();
    chk("oa_clr", rx_valid, 0);
    repeat (3) tick();

    // streaming, no idle gap
    o0 = n_ovr;
    log_q.delete();
    send_frame(8'h00, 1'b1, 10, 1);
    send_frame(8'hFF, 1'b1, 10, 1);
    send_frame(8'h55, 1'b1, 10, 1);
    send_frame(8'hAA, 1'b1, 10, 1);
    repeat (4) tick();
    chk("st_count", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("st_b0", log_q[0], 8'h00);
      chk("st_b1", log_q[1], 8'hFF);
      chk("st_b2", log_q[2], 8'h55);
      chk("st_b3", log_q[3], 8'hAA);
    end
    chk("st_ferr", n_ferr - f0, 0);
    chk("st_ovr", n_ovr - o0, 0);
    chk("st_valid", rx_valid, 0);
    chk("st_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver, the receive-side counterpart of the SoC's transmit UART. Recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from the asynchronous `rxd` line using the same bit-period count as the transmitter. Presents each byte in a holding register with a valid/ack handshake to the bus/CPU side. Flags framing errors and overruns.

## Interface
- `BIT_CYCLES`, default 5209: clock cycles per bit. Must satisfy 4 ≤ BIT_CYCLES < 16384.
- `HALF_BIT`, default `BIT_CYCLES/2` (integer division, 2604): cycles from start-bit detection to the start-bit mid-sample.
- `sclk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rxd`  in  1  asynchronous serial input; idles high.
- `rx_data`  out  8  received byte; valid while `rx_valid`=1.
- `rx_valid`  out  1  holding register full.
- `rx_ack`  in  1  consumer strobe; pops the holding register.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: byte lost because the holding register was full.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Input sync: two flops, `rxd` → `s1` → `rx_s`. Both reset to 1.
- Counter: 14-bit down-counter `cnt`. In any timed state, if `cnt`≠0 it decrements; if `cnt`=0 the state action below fires on that edge.
- FSM states:
  - IDLE: if `rx_s`=0, go to START and load `cnt`=HALF_BIT-1.
  - START: at `cnt`=0, sample `rx_s`. If 0, go to DATA with `cnt`=BIT_CYCLES-1 and `idx`=0. If 1 (glitch), return to IDLE; no flags, no output.
  - DATA: at `cnt`=0, set `shift[idx]`=`rx_s` and reload `cnt`=BIT_CYCLES-1. If `idx`=7 go to STOP, otherwise increment `idx`.
  - STOP: at `cnt`=0, sample `rx_s`. If 1, deliver the byte (see Holding) and go to IDLE. If 0, pulse `frame_err`, discard the byte and go to BRK.
  - BRK: wait for `rx_s`=1, then go to IDLE. Handles a held-low line or break without producing spurious frames.
- Holding register `rx_data`/`rx_valid`:
  - Delivery while `rx_valid`=0: load `rx_data` and set `rx_valid`=1.
  - Delivery while `rx_valid`=1 with `rx_ack`=0 on the same edge: keep the old `rx_data`, keep `rx_valid`=1, pulse `overrun`; the new byte is lost.
  - Delivery and `rx_ack` on the same edge: load the new byte, `rx_valid` stays 1, no `overrun`.
  - `rx_ack` with no delivery: clear `rx_valid`. `rx_data` keeps its value.
  - `rx_ack` while `rx_valid`=0: ignored.
- Reset, on any edge with `reset`=1, including mid-frame:
  - state = IDLE; `cnt`, `idx`, `shift` = 0.
  - `rx_data`=0x00; `rx_valid`, `frame_err`, `overrun`, `busy` = 0.
  - Sync flops = 1.
  - A partially received frame is dropped. After reset releases, the receiver waits for a fresh high-to-low transition: a line already low enters START once `rx_s` reads 0.

## Timing
- Let `rxd` first be sampled low at edge t.
  - After edge t+1: `rx_s`=0.
  - After edge t+2: state = START, `busy`=1.
- Start mid-sample at edge t+2+HALF_BIT.
- Data bit i (0..7) sampled at edge t+2+HALF_BIT+(i+1)·BIT_CYCLES.
- Stop sampled at edge S = t+2+HALF_BIT+9·BIT_CYCLES.
  - After S: `rx_valid`=1 (or a `frame_err`/`overrun` pulse for exactly one cycle).
  - After S: `busy`=0, except on a framing error, where `busy` stays 1 through BRK.
- The byte is available at mid-stop-bit. IDLE is re-entered at that point, so a start bit immediately following the stop bit is detected with no lost frame.
- `rx_ack` → `rx_valid` low after the next edge (latency 1). Back-to-back acks are legal.
- Outputs are registered; no combinational path from `rxd` or `rx_ack` to any output.

## Test plan
Bench uses BIT_CYCLES=16 (HALF_BIT=8).
- Single frame 0xA5, stop=1, `rx_ack` held 0 → `rx_valid` rises 2+8+144=154 edges after the start-bit low sample; `rx_data`=0xA5; no flags.
- Glitch: `rxd` low for 3 cycles, then high → FSM enters START and returns to IDLE at the mid-sample; `rx_valid`, `frame_err` and `overrun` remain 0.
- Framing error: frame 0x3C with stop bit 0, line held low for 40 more cycles, then high → one `frame_err` pulse; `rx_valid`=0; `busy` stays 1 until `rx_s` returns high; a following 0x11 frame is received correctly.
- Overrun: frames 0x01 then 0x02 back-to-back, no ack → `rx_data`=0x01 and one `overrun` pulse at the second stop sample. Repeat with `rx_ack` asserted on the exact delivery edge → `rx_data`=0x02, `rx_valid`=1, no `overrun`.
- Reset mid-frame: assert `reset` during data bit 4 of 0xFF → all outputs 0 after the edge. Release, then send 0x5A → `rx_data`=0x5A, no residual bits from the aborted frame.
- Streaming: 4 consecutive frames (0x00, 0xFF, 0x55, 0xAA), no idle gap, acking each within 1 cycle of `rx_valid` → all four bytes received in order; no flags.
